// File: rtl/uart_tx_sched.sv
// Round-robin scheduler and frame sequencer sharing one UART TX line among NUM_REQ requesters.
// Grants are aligned to baud_tick; each tick advances exactly one bit of the frame.
module uart_tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           baud_tick,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           tx,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           frame_done
);

  localparam int          PTR_W = $clog2(NUM_REQ);
  localparam int          CNT_W = $clog2(DATA_BITS);
  localparam int unsigned NR    = NUM_REQ;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $fatal(1, "uart_tx_sched: NUM_REQ must be 2..8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $fatal(1, "uart_tx_sched: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $fatal(1, "uart_tx_sched: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_sched: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_nxt;
  logic [PTR_W-1:0]     owner_nxt;
  logic [NUM_REQ-1:0]   ack_nxt;
  logic                 tx_nxt, busy_nxt, done_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bit, par_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_nxt;
  logic                 stop_cnt, stop_nxt;
  logic                 win_valid, grant;
  logic [PTR_W-1:0]     win_idx;
  logic [DATA_BITS-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*DATA_BITS +: DATA_BITS];
  end

  // First pending requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [PTR_W-1:0] cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      cand = PTR_W'((32'(rr_ptr) + i) % NR);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    busy_nxt  = busy;
    ack_nxt   = '0;
    owner_nxt = owner;
    done_nxt  = 1'b0;
    rr_nxt    = rr_ptr;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    bit_nxt   = bit_cnt;
    stop_nxt  = stop_cnt;
    grant     = 1'b0;
    if (baud_tick) begin
      case (state)
        S_IDLE: grant = win_valid;
        // Data leaves through a right shift register, so tx always takes shreg[0].
        S_START: begin
          state_nxt = S_DATA;
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
          bit_nxt   = '0;
        end
        S_DATA: begin
          if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state_nxt = S_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
              stop_nxt  = 1'b0;
            end
          end else begin
            bit_nxt   = bit_cnt + 1'b1;
            tx_nxt    = shreg[0];
            shreg_nxt = shreg >> 1;
          end
        end
        S_PARITY: begin
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
          stop_nxt  = 1'b0;
        end
        S_STOP: begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            done_nxt = 1'b1;
            if (win_valid) begin
              grant = 1'b1;
            end else begin
              state_nxt = S_IDLE;
              busy_nxt  = 1'b0;
              tx_nxt    = 1'b1;
            end
          end else begin
            stop_nxt = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
      if (grant) begin
        state_nxt         = S_START;
        tx_nxt            = 1'b0;
        busy_nxt          = 1'b1;
        ack_nxt[win_idx]  = 1'b1;
        owner_nxt         = win_idx;
        rr_nxt            = win_idx;
        shreg_nxt         = req_bytes[win_idx];
        par_nxt           = (PARITY == 1) ? ^req_bytes[win_idx] : ~^req_bytes[win_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      ack        <= '0;
      owner      <= '0;
      frame_done <= 1'b0;
      rr_ptr     <= PTR_W'(NUM_REQ - 1);
      shreg      <= '0;
      par_bit    <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      ack        <= ack_nxt;
      owner      <= owner_nxt;
      frame_done <= done_nxt;
      rr_ptr     <= rr_nxt;
      shreg      <= shreg_nxt;
      par_bit    <= par_nxt;
      bit_cnt    <= bit_nxt;
      stop_cnt   <= stop_nxt;
    end
  end

endmodule
